// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: state encoding,
// stall/flush counter width and a parameter sanity check.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } hz_state_e;

   localparam int CNT_W = $clog2(5);

   // Load-use bubbles are limited to 1..4 and redirect kill depth to 2..4.
   function automatic bit hz_params_ok(input int loadStall, input int flushCyc);
      return (loadStall >= 1) && (loadStall <= 4) && (flushCyc >= 2) && (flushCyc <= 4);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline and the hazard controller.
// The master side is the pipeline; the slave side is the hazard controller.
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  rs1_used;
   logic                  rs2_used;
   logic                  ID_EX_MemRead;
   logic [REG_ADDR_W-1:0] ID_EX_rd;
   logic                  ex_redirect;
   logic                  mem_wait;
   logic                  hz_PC_Write;
   logic                  hz_IF_ID_Write;
   logic                  hz_IF_ID_flush;
   logic                  hz_bubble;
   logic                  hz_pipe_hold;

   modport master (
      output rs1, rs2, rs1_used, rs2_used, ID_EX_MemRead, ID_EX_rd, ex_redirect, mem_wait,
      input  hz_PC_Write, hz_IF_ID_Write, hz_IF_ID_flush, hz_bubble, hz_pipe_hold
   );

   modport slave (
      input  rs1, rs2, rs1_used, rs2_used, ID_EX_MemRead, ID_EX_rd, ex_redirect, mem_wait,
      output hz_PC_Write, hz_IF_ID_Write, hz_IF_ID_flush, hz_bubble, hz_pipe_hold
   );
endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Free-running 32-bit event counters for load-use bubbles and IF/ID flushes.
// Instantiated only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_stallInc,
   input  logic        i_flushInc,
   output logic [31:0] o_stallCnt,
   output logic [31:0] o_flushCnt
);

   logic [31:0] r_stallCnt;
   logic [31:0] r_flushCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (i_stallInc) r_stallCnt <= r_stallCnt + 32'd1;
         if (i_flushInc) r_flushCnt <= r_flushCnt + 32'd1;
      end
   end

   assign o_stallCnt = r_stallCnt;
   assign o_flushCnt = r_flushCnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stalls, redirect flushing and memory-wait freeze.
// Optional performance counters (hz_stall_cnt/hz_flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_STALL = 1,
   parameter int FLUSH_CYC  = 2
) (
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] hz_stall_cnt,
   output logic [31:0] hz_flush_cnt
`endif
);

   if (!hz_params_ok(LOAD_STALL, FLUSH_CYC)) begin : g_badParams
      $error("hazard_ctrl: LOAD_STALL must be 1..4 and FLUSH_CYC 2..4");
   end

   localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 2);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   hz_state_e        r_state;
   hz_state_e        w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic             w_luHit;
   logic             w_pcWrite;
   logic             w_ifIdWrite;
   logic             w_flush;
   logic             w_bubble;
   logic             w_hold;

   // x0 never carries a real dependency, and an unread source cannot create one.
   assign w_luHit = hz.ID_EX_MemRead && (hz.ID_EX_rd != '0) &&
                    ((hz.rs1_used && (hz.rs1 == hz.ID_EX_rd)) ||
                     (hz.rs2_used && (hz.rs2 == hz.ID_EX_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      w_hold      = 1'b0;
      if (rst) begin
         w_nextState = IDLE;
         w_nextCnt   = '0;
      end else if (hz.mem_wait) begin
         w_hold = 1'b1;
      end else if (hz.ex_redirect) begin
         w_pcWrite   = 1'b1;
         w_ifIdWrite = 1'b1;
         w_flush     = 1'b1;
         w_bubble    = 1'b1;
         if (FLUSH_CYC > 2) begin
            w_nextState = FLUSH;
            w_nextCnt   = FLUSH_INIT;
         end else begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      end else begin
         unique case (r_state)
            LU_STALL: begin
               w_bubble  = 1'b1;
               w_nextCnt = r_cnt - CNT_ONE;
               if (r_cnt <= CNT_ONE) w_nextState = IDLE;
            end
            FLUSH: begin
               w_pcWrite   = 1'b1;
               w_ifIdWrite = 1'b1;
               w_flush     = 1'b1;
               w_nextCnt   = r_cnt - CNT_ONE;
               if (r_cnt <= CNT_ONE) w_nextState = IDLE;
            end
            default: begin
               if (w_luHit) begin
                  w_bubble = 1'b1;
                  if (LOAD_STALL > 1) begin
                     w_nextState = LU_STALL;
                     w_nextCnt   = STALL_INIT;
                  end
               end else begin
                  w_pcWrite   = 1'b1;
                  w_ifIdWrite = 1'b1;
               end
            end
         endcase
      end
   end

   assign hz.hz_PC_Write    = w_pcWrite;
   assign hz.hz_IF_ID_Write = w_ifIdWrite;
   assign hz.hz_IF_ID_flush = w_flush;
   assign hz.hz_bubble      = w_bubble;
   assign hz.hz_pipe_hold   = w_hold;

`ifdef HAZARD_PERF_CNT_EN
   // A bubble outside a redirect cycle can only come from a load-use stall.
   logic w_luBubble;
   assign w_luBubble = w_bubble & ~hz.ex_redirect;

   hazard_perf_cnt u_perfCnt (
      .clk        (clk),
      .rst        (rst),
      .i_stallInc (w_luBubble),
      .i_flushInc (w_flush),
      .o_stallCnt (hz_stall_cnt),
      .o_flushCnt (hz_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl across three parameter sets sharing one stimulus bus.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

   localparam logic [4:0] NORM = 5'b11000;
   localparam logic [4:0] LU   = 5'b00010;
   localparam logic [4:0] RED  = 5'b11110;
   localparam logic [4:0] FLS  = 5'b11100;
   localparam logic [4:0] HOLD = 5'b00001;
   localparam logic [4:0] ZERO = 5'b00000;

   typedef struct {
      int         sel;
      string      tag;
      logic [4:0] exp;
   } sbEntry_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, exRd;
   logic       rs1Used, rs2Used, exMemRead, exRedirect, memWait;

   int errorCount = 0;
   int checkCount = 0;
   sbEntry_t scoreboard[$];

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_ADDR_W(5)) ifA ();
   hazard_ctrl_if #(.REG_ADDR_W(5)) ifB ();
   hazard_ctrl_if #(.REG_ADDR_W(5)) ifC ();

   // Every DUT sees the same input bus; only the selected one is scored.
   assign {ifA.rs1, ifB.rs1, ifC.rs1}                               = {3{rs1}};
   assign {ifA.rs2, ifB.rs2, ifC.rs2}                               = {3{rs2}};
   assign {ifA.rs1_used, ifB.rs1_used, ifC.rs1_used}                = {3{rs1Used}};
   assign {ifA.rs2_used, ifB.rs2_used, ifC.rs2_used}                = {3{rs2Used}};
   assign {ifA.ID_EX_MemRead, ifB.ID_EX_MemRead, ifC.ID_EX_MemRead} = {3{exMemRead}};
   assign {ifA.ID_EX_rd, ifB.ID_EX_rd, ifC.ID_EX_rd}                = {3{exRd}};
   assign {ifA.ex_redirect, ifB.ex_redirect, ifC.ex_redirect}       = {3{exRedirect}};
   assign {ifA.mem_wait, ifB.mem_wait, ifC.mem_wait}                = {3{memWait}};

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stallCntA, flushCntA, stallCntB, flushCntB, stallCntC, flushCntC;
`endif

   hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .FLUSH_CYC(2)) dutA (
      .clk (clk),
      .rst (rst),
      .hz  (ifA.slave)
`ifdef HAZARD_PERF_CNT_EN
      , .hz_stall_cnt (stallCntA), .hz_flush_cnt (flushCntA)
`endif
   );

   hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .FLUSH_CYC(3)) dutB (
      .clk (clk),
      .rst (rst),
      .hz  (ifB.slave)
`ifdef HAZARD_PERF_CNT_EN
      , .hz_stall_cnt (stallCntB), .hz_flush_cnt (flushCntB)
`endif
   );

   hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(2), .FLUSH_CYC(2)) dutC (
      .clk (clk),
      .rst (rst),
      .hz  (ifC.slave)
`ifdef HAZARD_PERF_CNT_EN
      , .hz_stall_cnt (stallCntC), .hz_flush_cnt (flushCntC)
`endif
   );

   function automatic logic [4:0] observe(input int sel);
      case (sel)
         0:       return {ifA.hz_PC_Write, ifA.hz_IF_ID_Write, ifA.hz_IF_ID_flush, ifA.hz_bubble, ifA.hz_pipe_hold};
         1:       return {ifB.hz_PC_Write, ifB.hz_IF_ID_Write, ifB.hz_IF_ID_flush, ifB.hz_bubble, ifB.hz_pipe_hold};
         default: return {ifC.hz_PC_Write, ifC.hz_IF_ID_Write, ifC.hz_IF_ID_flush, ifC.hz_bubble, ifC.hz_pipe_hold};
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs (after the rising edge) and queue the expected
   // {PC_Write, IF_ID_Write, IF_ID_flush, bubble, pipe_hold} for that cycle.
   task automatic applyStimulus(input int sel, input string tag,
                                input logic r, input logic mw, input logic red,
                                input logic mr, input logic [4:0] rd,
                                input logic [4:0] s1, input logic u1,
                                input logic [4:0] s2, input logic u2,
                                input logic [4:0] exp);
      sbEntry_t e;
      rst        = r;
      memWait    = mw;
      exRedirect = red;
      exMemRead  = mr;
      exRd       = rd;
      rs1        = s1;
      rs1Used    = u1;
      rs2        = s2;
      rs2Used    = u2;
      e.sel = sel;
      e.tag = tag;
      e.exp = exp;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Combinational outputs are settled by the falling edge.
   always @(negedge clk) begin
      if (scoreboard.size() > 0) begin
         sbEntry_t e;
         e = scoreboard.pop_front();
         checkOutput(e.tag, {27'd0, observe(e.sel)}, {27'd0, e.exp});
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; memWait = 1'b0; exRedirect = 1'b0; exMemRead = 1'b0;
      exRd = '0; rs1 = '0; rs2 = '0; rs1Used = 1'b0; rs2Used = 1'b0;
      @(posedge clk);
      #1;

      // LOAD_STALL=1, FLUSH_CYC=2
      applyStimulus(0, "A.reset",     1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ZERO);
      applyStimulus(0, "A.idle",      0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, NORM);
      applyStimulus(0, "A.luRs1",     0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd2, 1, LU);
      applyStimulus(0, "A.luDone",    0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd2, 1, NORM);
      applyStimulus(0, "A.luRs2",     0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 1, LU);
      applyStimulus(0, "A.luRs2Done", 0, 0, 0, 0, 5'd0, 5'd7, 0, 5'd7, 1, NORM);
      applyStimulus(0, "A.redirect",  0, 0, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, RED);
      applyStimulus(0, "A.redirNext", 0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, NORM);
      applyStimulus(0, "A.memWait",   0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd2, 1, HOLD);
      applyStimulus(0, "A.rstComb",   1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd2, 1, ZERO);

      // LOAD_STALL=3, FLUSH_CYC=3
      applyStimulus(1, "B.reset",     1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ZERO);
      applyStimulus(1, "B.lu0",       0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, LU);
      applyStimulus(1, "B.lu1",       0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, LU);
      applyStimulus(1, "B.lu2",       0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, LU);
      applyStimulus(1, "B.luDone",    0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, NORM);
      applyStimulus(1, "B.rdX0",      0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, NORM);
      applyStimulus(1, "B.rs2Unused", 0, 0, 0, 1, 5'd5, 5'd3, 1, 5'd5, 0, NORM);
      applyStimulus(1, "B.redirect",  0, 0, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, RED);
      applyStimulus(1, "B.flush1",    0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, FLS);
      applyStimulus(1, "B.flushDone", 0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, NORM);
      applyStimulus(1, "B.redirLu",   0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd2, 1, RED);
      applyStimulus(1, "B.redirLu1",  0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd2, 1, FLS);
      applyStimulus(1, "B.redirLu2",  0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd2, 1, NORM);
      applyStimulus(1, "B.mwLu0",     0, 0, 0, 1, 5'd6, 5'd1, 0, 5'd6, 1, LU);
      applyStimulus(1, "B.mwLu1",     0, 0, 0, 0, 5'd0, 5'd1, 0, 5'd6, 1, LU);
      applyStimulus(1, "B.mwHold0",   0, 1, 0, 0, 5'd0, 5'd1, 0, 5'd6, 1, HOLD);
      applyStimulus(1, "B.mwHold1",   0, 1, 0, 0, 5'd0, 5'd1, 0, 5'd6, 1, HOLD);
      applyStimulus(1, "B.mwLu2",     0, 0, 0, 0, 5'd0, 5'd1, 0, 5'd6, 1, LU);
      applyStimulus(1, "B.mwLuDone",  0, 0, 0, 0, 5'd0, 5'd1, 0, 5'd6, 1, NORM);
      applyStimulus(1, "B.mwRedir",   0, 1, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, HOLD);
      applyStimulus(1, "B.mwRedirGo", 0, 0, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, RED);
      applyStimulus(1, "B.mwFlHold",  0, 1, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, HOLD);
      applyStimulus(1, "B.mwFlush1",  0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, FLS);
      applyStimulus(1, "B.mwFlDone",  0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, NORM);
      applyStimulus(1, "B.rstLu0",    0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, LU);
      applyStimulus(1, "B.rstMid",    1, 0, 0, 0, 5'd0, 5'd9, 1, 5'd0, 0, ZERO);
      applyStimulus(1, "B.rstAfter",  0, 0, 0, 0, 5'd0, 5'd9, 1, 5'd0, 0, NORM);

      // LOAD_STALL=2, FLUSH_CYC=2
      applyStimulus(2, "C.reset",     1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ZERO);
      applyStimulus(2, "C.luA0",      0, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, LU);
      applyStimulus(2, "C.luA1",      0, 0, 0, 0, 5'd0, 5'd4, 1, 5'd0, 0, LU);
      applyStimulus(2, "C.luADone",   0, 0, 0, 0, 5'd0, 5'd4, 1, 5'd0, 0, NORM);
      applyStimulus(2, "C.luB0",      0, 0, 0, 1, 5'd8, 5'd0, 0, 5'd8, 1, LU);
      applyStimulus(2, "C.luBHold",   0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd8, 1, HOLD);
      applyStimulus(2, "C.luB1",      0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd8, 1, LU);
      applyStimulus(2, "C.luBDone",   0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd8, 1, NORM);
      applyStimulus(2, "C.redirect",  0, 0, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, RED);
      applyStimulus(2, "C.redirNext", 0, 0, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1, NORM);

`ifdef HAZARD_PERF_CNT_EN
      checkOutput("C.stallCnt", stallCntC, 32'd4);
      checkOutput("C.flushCnt", flushCntC, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("C.stallCntRst", stallCntC, 32'd0);
      checkOutput("C.flushCntRst", flushCntC, 32'd0);
`endif

      for (int i = 0; i < 20 && scoreboard.size() > 0; i++) @(posedge clk);
      if (scoreboard.size() > 0)
         checkOutput("drain", scoreboard.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
